// File: rtl/avm_arb_pkg.sv
// rtl/avm_arb_pkg.sv - shared types and constants for the Avalon-MM fetch/data arbiter
//
// Purpose : FSM state enum, grant enum and the all-ones byte-enable constant
//           used by avalon_mem_arbiter and avm_arb_pick.
// Ports   : none (package).
package avm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    RELEASE   = 2'd3
  } arbStateT;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arbGntT;

  // Wide enough for any realistic DATA_W/8; users slice the low bits they need.
  localparam int                    BE_MAX_W    = 128;
  localparam logic [BE_MAX_W-1:0]   BE_ALL_ONES = '1;

endpackage

// File: rtl/avalon_mem_arbiter_if.sv
// rtl/avalon_mem_arbiter_if.sv - Avalon-MM master bus bundle for the arbiter
//
// Purpose : groups the Avalon-MM master port signals.
// Ports   : master modport (arbiter side) drives address/read/write/writedata/
//           byteenable and receives readdata/waitrequest/readdatavalid;
//           slave modport is the interconnect/memory view of the same wires.
interface avalon_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/avm_arb_pick.sv
// rtl/avm_arb_pick.sv - combinational two-way grant picker
//
// Purpose : chooses fetch or data when the arbiter is idle.
//           AVM_ARB_RR_EN defined   : round-robin on a tie (requester not granted last wins).
//           AVM_ARB_RR_EN undefined : fixed priority, data beats fetch; lastGnt unused.
// Ports   : IReq, DReq - level requests; lastGnt - previous grant; gnt - chosen side.
module avm_arb_pick
  import avm_arb_pkg::*;
(
  input  logic   IReq,
  input  logic   DReq,
  input  arbGntT lastGnt,
  output arbGntT gnt
);

`ifdef AVM_ARB_RR_EN
  always_comb begin
    gnt = GNT_D;
    if (IReq && !DReq) begin
      gnt = GNT_I;
    end else if (IReq && DReq && lastGnt == GNT_D) begin
      gnt = GNT_I;
    end
  end
`else
  logic unusedLastGnt;
  assign unusedLastGnt = lastGnt;

  always_comb begin
    gnt = GNT_D;
    if (IReq && !DReq) begin
      gnt = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - shares one Avalon-MM master between fetch and load/store
//
// Purpose : one outstanding Avalon transaction at a time; each requester holds a
//           level request until its one-cycle Done pulse and must drop it before
//           it is served again. Tie policy selected by AVM_ARB_RR_EN (see avm_arb_pick).
// Ports   : CLK, RST_N (async active-low)
//           IReq/IAddr -> IData/IDone        fetch requester (reads only, all byte lanes)
//           DReq/DWe/DAddr/DWData/DBe -> DRData/DDone   data requester
//           avm                              Avalon-MM master bundle (master modport)
module avalon_mem_arbiter
  import avm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IReq,
  input  logic [ADDR_W-1:0]   IAddr,
  output logic [DATA_W-1:0]   IData,
  output logic                IDone,
  input  logic                DReq,
  input  logic                DWe,
  input  logic [ADDR_W-1:0]   DAddr,
  input  logic [DATA_W-1:0]   DWData,
  input  logic [DATA_W/8-1:0] DBe,
  output logic [DATA_W-1:0]   DRData,
  output logic                DDone,
  avalon_mem_arbiter_if.master avm
);

  localparam int BE_W = DATA_W / 8;

  arbStateT          state, stateNext;
  arbGntT            gnt, pickGnt, lastGnt;
  logic              weQ, readQ, writeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [BE_W-1:0]   beQ;
  logic              load, complete, capture, grantedReq;

  assign avm.avm_address    = addrQ;
  assign avm.avm_read       = readQ;
  assign avm.avm_write      = writeQ;
  assign avm.avm_writedata  = wdataQ;
  assign avm.avm_byteenable = beQ;

  avm_arb_pick uPick (
    .IReq    (IReq),
    .DReq    (DReq),
    .lastGnt (lastGnt),
    .gnt     (pickGnt)
  );

`ifdef AVM_ARB_RR_EN
  // Reset to "fetch granted last" so the first tie goes to data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    lastGnt <= GNT_I;
    else if (load) lastGnt <= pickGnt;
  end
`else
  assign lastGnt = GNT_D;
`endif

  assign grantedReq = (gnt == GNT_I) ? IReq : DReq;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    complete  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (IReq || DReq) begin
          load      = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm.avm_waitrequest) begin
          if (weQ) begin
            complete  = 1'b1;
            stateNext = RELEASE;
          end else begin
            stateNext = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (avm.avm_readdatavalid) begin
          complete  = 1'b1;
          capture   = 1'b1;
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        // Holds until the served requester lets go, so a slow drop cannot re-issue.
        if (!grantedReq) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt    <= GNT_I;
      weQ    <= 1'b0;
      readQ  <= 1'b0;
      writeQ <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      IData  <= '0;
      DRData <= '0;
      IDone  <= 1'b0;
      DDone  <= 1'b0;
    end else begin
      IDone <= 1'b0;
      DDone <= 1'b0;
      // Only the winner's inputs are sampled; the loser is left untouched.
      if (load) begin
        gnt <= pickGnt;
        if (pickGnt == GNT_D) begin
          addrQ  <= DAddr;
          wdataQ <= DWData;
          beQ    <= DBe;
          weQ    <= DWe;
          readQ  <= !DWe;
          writeQ <= DWe;
        end else begin
          addrQ  <= IAddr;
          wdataQ <= '0;
          beQ    <= BE_ALL_ONES[BE_W-1:0];
          weQ    <= 1'b0;
          readQ  <= 1'b1;
          writeQ <= 1'b0;
        end
      end
      if (state == ISSUE && !avm.avm_waitrequest) begin
        readQ  <= 1'b0;
        writeQ <= 1'b0;
      end
      if (complete) begin
        if (gnt == GNT_I) IDone <= 1'b1;
        else              DDone <= 1'b1;
      end
      if (capture) begin
        if (gnt == GNT_I) IData  <= avm.avm_readdata;
        else              DRData <= avm.avm_readdata;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb/tb_avalon_mem_arbiter.sv - directed self-checking bench for avalon_mem_arbiter
module tb_avalon_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                IReq, DReq, DWe;
  logic [ADDR_W-1:0]   IAddr, DAddr;
  logic [DATA_W-1:0]   DWData, IData, DRData;
  logic [DATA_W/8-1:0] DBe;
  logic                IDone, DDone;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  avalon_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  avalon_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IReq   (IReq),
    .IAddr  (IAddr),
    .IData  (IData),
    .IDone  (IDone),
    .DReq   (DReq),
    .DWe    (DWe),
    .DAddr  (DAddr),
    .DWData (DWData),
    .DBe    (DBe),
    .DRData (DRData),
    .DDone  (DDone),
    .avm    (avm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic expD;
    RST_N = 1'b0;
    IReq = 0; DReq = 0; DWe = 0; IAddr = '0; DAddr = '0; DWData = '0; DBe = '0;
    avm.avm_readdata = '0; avm.avm_waitrequest = 1'b0; avm.avm_readdatavalid = 1'b0;
    tick; tick;
    chk("rst_read",  {31'd0, avm.avm_read},  32'd0);
    chk("rst_write", {31'd0, avm.avm_write}, 32'd0);
    chk("rst_addr",  avm.avm_address, 32'd0);
    chk("rst_done",  {30'd0, IDone, DDone}, 32'd0);
    chk("rst_idata", IData, 32'd0);
    chk("rst_drdata", DRData, 32'd0);
    RST_N = 1'b1;
    tick;

    // Data read of 0x100, readdatavalid two cycles after acceptance.
    DReq = 1; DWe = 0; DAddr = 32'h100; DBe = 4'hF;
    tick;
    chk("rd_read", {31'd0, avm.avm_read}, 32'd1);
    chk("rd_write", {31'd0, avm.avm_write}, 32'd0);
    chk("rd_addr", avm.avm_address, 32'h100);
    chk("rd_be", {28'd0, avm.avm_byteenable}, 32'hF);
    tick;
    chk("rd_read_drop", {31'd0, avm.avm_read}, 32'd0);
    chk("rd_nodone", {31'd0, DDone}, 32'd0);
    tick;
    avm.avm_readdatavalid = 1; avm.avm_readdata = 32'hDEADBEEF;
    tick;
    chk("rd_ddone", {31'd0, DDone}, 32'd1);
    chk("rd_drdata", DRData, 32'hDEADBEEF);
    chk("rd_idata_kept", IData, 32'd0);
    avm.avm_readdatavalid = 0; avm.avm_readdata = '0; DReq = 0;
    tick;
    chk("rd_ddone_pulse", {31'd0, DDone}, 32'd0);
    // Stray readdatavalid while idle must be ignored.
    avm.avm_readdatavalid = 1; avm.avm_readdata = 32'h00000BAD;
    tick;
    chk("stray_drdata", DRData, 32'hDEADBEEF);
    chk("stray_idata", IData, 32'd0);
    chk("stray_done", {30'd0, IDone, DDone}, 32'd0);
    avm.avm_readdatavalid = 0;

    // Write with three wait states, then requester holds DReq 5 cycles after DDone.
    avm.avm_waitrequest = 1;
    DReq = 1; DWe = 1; DAddr = 32'h200; DWData = 32'h12345678; DBe = 4'h3;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("wr_held", {31'd0, avm.avm_write}, 32'd1);
      chk("wr_addr", avm.avm_address, 32'h200);
      chk("wr_data", avm.avm_writedata, 32'h12345678);
      chk("wr_be", {28'd0, avm.avm_byteenable}, 32'h3);
      chk("wr_nodone", {31'd0, DDone}, 32'd0);
      if (k == 3) avm.avm_waitrequest = 0;
      tick;
    end
    chk("wr_ddone", {31'd0, DDone}, 32'd1);
    chk("wr_write_drop", {31'd0, avm.avm_write}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("hold_nodone", {31'd0, DDone}, 32'd0);
      chk("hold_noissue", {30'd0, avm.avm_read, avm.avm_write}, 32'd0);
    end
    DReq = 0;
    tick;
    chk("hold_release", {30'd0, avm.avm_read, avm.avm_write}, 32'd0);

    // Reset asserted in WAIT_DATA, then a late readdatavalid.
    DReq = 1; DWe = 0; DAddr = 32'h300; DBe = 4'hF;
    tick;
    chk("rw_read", {31'd0, avm.avm_read}, 32'd1);
    tick;
    RST_N = 0;
    #1;
    chk("rw_async_read", {31'd0, avm.avm_read}, 32'd0);
    chk("rw_async_addr", avm.avm_address, 32'd0);
    chk("rw_async_drdata", DRData, 32'd0);
    DReq = 0;
    tick;
    RST_N = 1;
    avm.avm_readdatavalid = 1; avm.avm_readdata = 32'h55555555;
    tick;
    chk("rw_late_done", {30'd0, IDone, DDone}, 32'd0);
    chk("rw_late_drdata", DRData, 32'd0);
    chk("rw_late_cmd", {30'd0, avm.avm_read, avm.avm_write}, 32'd0);
    avm.avm_readdatavalid = 0; avm.avm_readdata = '0;

    // Simultaneous requests, four rounds (pointer freshly reset to favour data).
    for (int r = 0; r < 4; r++) begin
`ifdef AVM_ARB_RR_EN
      expD = (r % 2 == 0);
`else
      expD = 1'b1;
`endif
      IReq = 1; DReq = 1; DWe = 0; DBe = 4'hF;
      IAddr = 32'h1000 + r * 4; DAddr = 32'h2000 + r * 4;
      tick;
      chk("tie_addr", avm.avm_address, expD ? (32'h2000 + r * 4) : (32'h1000 + r * 4));
      tick;
      avm.avm_readdatavalid = 1; avm.avm_readdata = 32'hA0000000 + r;
      tick;
      chk("tie_ddone", {31'd0, DDone}, {31'd0, expD});
      chk("tie_idone", {31'd0, IDone}, {31'd0, !expD});
      if (expD) chk("tie_drdata", DRData, 32'hA0000000 + r);
      else      chk("tie_idata", IData, 32'hA0000000 + r);
      avm.avm_readdatavalid = 0; IReq = 0; DReq = 0;
      tick;
    end

    // Fetch request dropped during ISSUE still completes.
    avm.avm_waitrequest = 1;
    IReq = 1; IAddr = 32'h3000;
    tick;
    chk("drop_read", {31'd0, avm.avm_read}, 32'd1);
    chk("drop_addr", avm.avm_address, 32'h3000);
    chk("drop_be", {28'd0, avm.avm_byteenable}, 32'hF);
    IReq = 0;
    tick;
    avm.avm_waitrequest = 0;
    tick;
    chk("drop_accept", {31'd0, avm.avm_read}, 32'd0);
    avm.avm_readdatavalid = 1; avm.avm_readdata = 32'hCAFEF00D;
    tick;
    chk("drop_idone", {31'd0, IDone}, 32'd1);
    chk("drop_idata", IData, 32'hCAFEF00D);
    avm.avm_readdatavalid = 0;
    tick;
    chk("drop_idone_pulse", {31'd0, IDone}, 32'd0);
    DReq = 1; DWe = 0; DAddr = 32'h400;
    tick;
    chk("drop_back_idle", {31'd0, avm.avm_read}, 32'd1);
    chk("drop_next_addr", avm.avm_address, 32'h400);
    DReq = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
